// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a small prefetch queue in front of IF/ID.
// Hides instruction-memory wait states and honours stall, bubble and redirect.
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0001_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] IAD,
  input  logic [31:0] IDT,
  input  logic        iready_n,
  input  logic        branch_PC_contral,
  input  logic [31:0] branch_target,
  input  logic        stall_ID,
  input  logic        nop_IF,
  output logic [31:0] Instraction_pype,
  output logic [31:0] PC_pype,
  output logic        valid_pype,
  output logic [2:0]  q_count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [3:0] QD = 4'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   qpc_q [QDEPTH];
  logic [31:0]   qpc_d [QDEPTH];
  logic [31:0]   qins_q [QDEPTH];
  logic [31:0]   qins_d [QDEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   ins_q, ins_d;
  logic [31:0]   opc_q, opc_d;
  logic          vld_q, vld_d;
  logic          push, pop;

  always_comb begin
    pc_d   = pc_q;
    qpc_d  = qpc_q;
    qins_d = qins_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    ins_d  = ins_q;
    opc_d  = opc_q;
    vld_d  = vld_q;
    // push allowance uses pre-pop occupancy
    push   = !iready_n && (cnt_q < QD);
    pop    = 1'b0;
    if (branch_PC_contral) begin
      pc_d  = branch_target;
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ins_d = NOP_INSTR;
      opc_d = '0;
      vld_d = 1'b0;
    end else begin
      pop = !stall_ID && !nop_IF && (cnt_q != 4'd0);
      if (push) begin
        qpc_d[wp_q]  = pc_q;
        qins_d[wp_q] = IDT;
        wp_d         = wp_q + 1'b1;
        pc_d         = pc_q + 32'd4;
      end
      if (stall_ID) begin
        ins_d = ins_q;
      end else if (nop_IF) begin
        ins_d = NOP_INSTR;
        vld_d = 1'b0;
      end else if (pop) begin
        ins_d = qins_q[rp_q];
        opc_d = qpc_q[rp_q];
        vld_d = 1'b1;
        rp_d  = rp_q + 1'b1;
      end else begin
        ins_d = NOP_INSTR;
        vld_d = 1'b0;
      end
      cnt_d = cnt_q + {3'b0, push} - {3'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ins_q <= NOP_INSTR;
      opc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ins_q <= ins_d;
      opc_q <= opc_d;
      vld_q <= vld_d;
    end
  end

  // queue storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    qpc_q  <= qpc_d;
    qins_q <= qins_d;
  end

  assign IAD              = pc_q;
  assign Instraction_pype = ins_q;
  assign PC_pype          = opc_q;
  assign valid_pype       = vld_q;
  assign q_count          = cnt_q[2:0];

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: queue-based reference model and a
// scoreboard monitor that checks every instruction handed to decode.
module tb_if_prefetch_stage;

  localparam logic [31:0] RST_PC = 32'h0001_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          QD     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_n = 1'b1;
  logic        br = 1'b0;
  logic        stall = 1'b0;
  logic        nop = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] iad, idt, ins, pcp;
  logic        vld;
  logic [2:0]  qc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0000_0F0F;
  endfunction

  assign idt = word(iad);

  if_prefetch_stage #(
    .RESET_PC(RST_PC), .QDEPTH(QD), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .IAD(iad), .IDT(idt),
    .iready_n(ir_n), .branch_PC_contral(br),
    .branch_target(tgt), .stall_ID(stall), .nop_IF(nop),
    .Instraction_pype(ins), .PC_pype(pcp),
    .valid_pype(vld), .q_count(qc)
  );

  // reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_fifo[$];
  logic [31:0] m_ins, m_pc;
  logic        m_vld, m_pcdef;
  logic [31:0] sb[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic mstep();
    bit can_push;
    logic [31:0] p;
    if (!rst) begin
      m_fpc = RST_PC; m_fifo = {};
      m_ins = NOP; m_pc = 0; m_vld = 0; m_pcdef = 1;
    end else if (br) begin
      m_fpc = tgt; m_fifo = {};
      m_ins = NOP; m_pc = 0; m_vld = 0; m_pcdef = 1;
    end else begin
      can_push = !ir_n && (m_fifo.size() < QD);
      if (stall) begin
      end else if (nop) begin
        m_ins = NOP; m_vld = 0;
      end else if (m_fifo.size() > 0) begin
        p = m_fifo.pop_front();
        m_ins = word(p); m_pc = p; m_vld = 1; m_pcdef = 1;
        sb.push_back(p);
      end else begin
        m_ins = NOP; m_vld = 0; m_pcdef = 0;
      end
      if (can_push) begin
        m_fifo.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic check();
    chk("iad", iad, m_fpc);
    chk("q_count", {29'b0, qc}, m_fifo.size());
    chk("valid", {31'b0, vld}, {31'b0, m_vld});
    if (!m_vld) chk("bubble_ins", ins, NOP);
    if (m_pcdef) chk("pc_pype", pcp, m_pc);
  endtask

  task automatic cyc(input logic r, input logic i, input logic b,
                     input logic [31:0] t, input logic s,
                     input logic n);
    rst = r; ir_n = i; br = b; tgt = t; stall = s; nop = n;
    mstep();
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  // monitor: a freshly loaded valid instruction must match the scoreboard
  logic l_ok = 1'b0;
  always @(posedge clk) l_ok <= rst && !br && !stall && !nop;

  always @(negedge clk) begin
    logic [31:0] e;
    if (l_ok && vld === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra: got pc %h expected none", pcp);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pcp, e);
        chk("sb_ins", ins, word(e));
      end
    end
  end

  initial begin
    logic [31:0] t;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0040, 0, 0);
    chk("rst_pc", pcp, 32'h0);
    chk("rst_iad", iad, RST_PC);
    // streaming
    repeat (6) cyc(1, 0, 0, 0, 0, 0);
    // stall fills queue, fetch stops
    repeat (4) cyc(1, 0, 0, 0, 1, 0);
    chk("stall_full", {29'b0, qc}, 32'd2);
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    // redirect while full and stalled
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 32'h0001_0100, 1, 0);
    chk("br_iad", iad, 32'h0001_0100);
    chk("br_q", {29'b0, qc}, 32'd0);
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    // drain, then sparse memory responses
    repeat (4) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (4) cyc(1, 1, 0, 0, 0, 0);
    // single bubble with a non-empty queue
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    // reset beats a simultaneous branch and response
    cyc(0, 0, 1, 32'h0002_0000, 0, 0);
    chk("rst2_iad", iad, RST_PC);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    // address wrap
    cyc(1, 0, 1, 32'hFFFF_FFF8, 0, 0);
    repeat (6) cyc(1, 0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0;
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 19) == 0, t,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    #2;
    chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
